// File: rtl/div.sv
// rtl/div.sv - 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_DETECT_EN adds div_zero and single-edge completion on divisor=0.
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        done
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic        div_zero
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q, neg_r;

  logic [31:0] abs_dd, abs_dv;
  logic [32:0] rem_sh;
  logic [31:0] sub;
  logic        ge;
  logic [31:0] quo_nxt, rem_nxt;
  logic [31:0] q_fin, r_fin;
  logic        last;
  logic        zero_hit;

  assign abs_dd = (sign && dividend[31]) ? (32'd0 - dividend) : dividend;
  assign abs_dv = (sign && divisor[31])  ? (32'd0 - divisor)  : divisor;

  // One restoring step: shift next dividend bit in, subtract if it fits.
  assign rem_sh  = {rem, quo[31]};
  assign ge      = (rem_sh >= {1'b0, dvs});
  assign sub     = rem_sh[31:0] - dvs;
  assign rem_nxt = ge ? sub : rem_sh[31:0];
  assign quo_nxt = {quo[30:0], ge};

  assign q_fin = neg_q ? (32'd0 - quo_nxt) : quo_nxt;
  assign r_fin = neg_r ? (32'd0 - rem_nxt) : rem_nxt;
  assign last  = (cnt == 6'd31);

`ifdef DIV_ZERO_DETECT_EN
  assign zero_hit = (divisor == 32'd0);
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start && !zero_hit) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 6'd0;
      quo   <= 32'd0;
      rem   <= 32'd0;
      dvs   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q     <= 32'd0;
      r     <= 32'd0;
      done  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          quo   <= abs_dd;
          rem   <= 32'd0;
          dvs   <= abs_dv;
          neg_q <= sign & (dividend[31] ^ divisor[31]);
          neg_r <= sign & dividend[31];
          cnt   <= 6'd0;
`ifdef DIV_ZERO_DETECT_EN
          // Zero divisor completes immediately with the raw dividend as remainder.
          if (zero_hit) begin
            done     <= 1'b1;
            q        <= 32'hFFFF_FFFF;
            r        <= dividend;
            div_zero <= 1'b1;
          end
`endif
        end
        RUN: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 6'd1;
          if (last) begin
            cnt  <= 6'd0;
            done <= 1'b1;
            q    <= q_fin;
            r    <= r_fin;
`ifdef DIV_ZERO_DETECT_EN
            div_zero <= 1'b0;
`endif
          end
        end
        default: cnt <= 6'd0;
      endcase
    end
  end

endmodule
